// File: rtl/ah_div_result_buffer.sv
// Result FIFO behind the pipelined signed divider. Issue credits limit buffered plus
// in-flight results to DEPTH, so a source that obeys issue_gnt can never overflow the FIFO.
module ah_div_result_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_req,
  output logic                  issue_gnt,
  input  logic                  div_valid,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic                  div_dbz,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_quotient,
  output logic                  m_dbz,
  output logic [CNT_W-1:0]      fill_count,
  output logic [CNT_W-1:0]      credits,
  output logic                  ovf_err
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [DATA_WIDTH:0] head;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fill_q;
  logic [CNT_W-1:0]    credit_q;
  logic                ovf_q;
  logic                full;
  logic                pop;
  logic                push;

  assign full       = (fill_q == DEPTH_C);
  assign m_valid    = (fill_q != '0);
  assign pop        = m_valid & m_ready;
  assign issue_gnt  = issue_req & (credit_q != '0);
  // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
  assign push       = div_valid & (~full | pop);

  assign head       = mem[rd_ptr];
  assign m_quotient = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_dbz      = m_valid & head[DATA_WIDTH];

  assign fill_count = fill_q;
  assign credits    = credit_q;
  assign ovf_err    = ovf_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {div_dbz, div_quotient};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_q   <= '0;
      credit_q <= DEPTH_C;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fill_q   <= fill_q + CNT_W'(push) - CNT_W'(pop);
      credit_q <= credit_q - CNT_W'(issue_gnt) + CNT_W'(pop);
      if (div_valid & full & ~pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ah_div_result_buffer.sv
// Bench for ah_div_result_buffer: a queue-based FIFO/credit model plus a fixed-latency
// divider stand-in, compared against the DUT every cycle and at scenario checkpoints.
module tb_ah_div_result_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int LAT   = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_req;
  logic          issue_gnt;
  logic          div_valid;
  logic [DW-1:0] div_quotient;
  logic          div_dbz;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_quotient;
  logic          m_dbz;
  logic [CW-1:0] fill_count;
  logic [CW-1:0] credits;
  logic          ovf_err;

  ah_div_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_req    (issue_req),
    .issue_gnt    (issue_gnt),
    .div_valid    (div_valid),
    .div_quotient (div_quotient),
    .div_dbz      (div_dbz),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_quotient   (m_quotient),
    .m_dbz        (m_dbz),
    .fill_count   (fill_count),
    .credits      (credits),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [8:0] d;
  } flight_t;

  int         n_chk = 0;
  int         n_err = 0;
  logic [8:0] mq[$];
  flight_t    fl[$];
  int         mcred = DEPTH;
  bit         movf = 1'b0;
  int         cyc = 0;
  int         gnt_cnt = 0;
  int         arr_cnt = 0;
  bit         force_dv = 1'b0;
  logic [8:0] force_d = '0;
  bit         use_nxt = 1'b0;
  logic [8:0] nxt_d = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: present divider output, compare against the model, then advance the model.
  task automatic tick();
    bit      from_fl;
    bit      exp_gnt;
    bit      exp_pop;
    bit      exp_push;
    bit      dut_gnt;
    flight_t e;
    from_fl = 1'b0;
    if (force_dv) begin
      div_valid = 1'b1;
      {div_dbz, div_quotient} = force_d;
    end else if (fl.size() != 0 && fl[0].due == cyc) begin
      div_valid = 1'b1;
      {div_dbz, div_quotient} = fl[0].d;
      from_fl = 1'b1;
    end else begin
      div_valid = 1'b0;
      {div_dbz, div_quotient} = 9'($urandom);
    end
    #3;
    exp_gnt = issue_req && (mcred != 0);
    dut_gnt = issue_gnt;
    if (!rst) begin
      chk("issue_gnt",  issue_gnt,  exp_gnt);
      chk("m_valid",    m_valid,    mq.size() != 0);
      chk("m_quotient", m_quotient, (mq.size() != 0) ? mq[0][7:0] : 8'h00);
      chk("m_dbz",      m_dbz,      (mq.size() != 0) ? mq[0][8] : 1'b0);
      chk("fill_count", fill_count, mq.size());
      chk("credits",    credits,    mcred);
      chk("ovf_err",    ovf_err,    movf);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      fl.delete();
      mcred = DEPTH;
      movf  = 1'b0;
    end else begin
      exp_pop  = (mq.size() != 0) && m_ready;
      exp_push = div_valid && ((mq.size() < DEPTH) || exp_pop);
      if (div_valid && mq.size() == DEPTH && !exp_pop) movf = 1'b1;
      if (exp_pop) void'(mq.pop_front());
      if (exp_push) mq.push_back({div_dbz, div_quotient});
      if (from_fl) begin
        void'(fl.pop_front());
        arr_cnt++;
      end
      if (dut_gnt) begin
        e.due = cyc + LAT;
        e.d   = use_nxt ? nxt_d : 9'($urandom);
        fl.push_back(e);
        gnt_cnt++;
      end
      mcred = mcred - int'(exp_gnt) + int'(exp_pop);
    end
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst       = 1'b1;
    issue_req = 1'b0;
    m_ready   = 1'b0;
    div_valid = 1'b0;
    {div_dbz, div_quotient} = '0;

    // Reset
    ticks(2);
    rst = 1'b0;
    chk("rst_credits", credits, 16);
    chk("rst_fill", fill_count, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_gnt", issue_gnt, 0);

    // Single flow
    use_nxt = 1'b1;
    nxt_d = {1'b0, 8'hFD};
    issue_req = 1'b1;
    tick();
    issue_req = 1'b0;
    use_nxt = 1'b0;
    chk("single_credit_taken", credits, 15);
    ticks(10);
    chk("single_not_yet", m_valid, 0);
    tick();
    chk("single_m_valid", m_valid, 1);
    chk("single_q", m_quotient, 8'hFD);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("single_credit_back", credits, 16);
    chk("single_empty", m_valid, 0);

    // Credit exhaustion
    gnt_cnt = 0;
    issue_req = 1'b1;
    ticks(20);
    chk("exhaust_grants", gnt_cnt, 16);
    chk("exhaust_gnt_low", issue_gnt, 0);
    issue_req = 1'b0;
    ticks(30);
    chk("exhaust_fill", fill_count, 16);
    chk("exhaust_ovf", ovf_err, 0);

    // Full with simultaneous push/pop, then overflow
    force_dv = 1'b1;
    force_d = {1'b0, 8'h5A};
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    force_d = {1'b0, 8'hA5};
    chk("full_pp_fill", fill_count, 16);
    chk("full_pp_ovf", ovf_err, 0);
    tick();
    force_dv = 1'b0;
    chk("ovf_set", ovf_err, 1);
    chk("ovf_fill", fill_count, 16);
    ticks(3);
    chk("ovf_sticky", ovf_err, 1);
    m_ready = 1'b1;
    ticks(15);
    chk("full_last_q", m_quotient, 8'h5A);
    ticks(2);
    m_ready = 1'b0;
    chk("full_drained", fill_count, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ovf", ovf_err, 0);

    // Divide by zero under backpressure
    force_dv = 1'b1;
    force_d = {1'b1, 8'h00};
    tick();
    force_d = {1'b0, 8'h77};
    tick();
    force_dv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("dbz_flag", m_dbz, 1);
      chk("dbz_q", m_quotient, 8'h00);
      tick();
    end
    m_ready = 1'b1;
    tick();
    chk("dbz_next_q", m_quotient, 8'h77);
    chk("dbz_next_flag", m_dbz, 0);
    tick();
    m_ready = 1'b0;

    // Random stream with pointer wrap and reset at result 37
    arr_cnt = 0;
    for (int i = 0; i < 3000 && arr_cnt < 37; i++) begin
      issue_req = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 99) < 60);
      tick();
    end
    chk("stream_arrivals_37", arr_cnt, 37);
    issue_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_credits", credits, 16);
    chk("midrst_fill", fill_count, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_ovf", ovf_err, 0);
    for (int i = 0; i < 3000 && arr_cnt < 40; i++) begin
      issue_req = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 99) < 60);
      tick();
    end
    chk("stream_arrivals_40", arr_cnt, 40);
    issue_req = 1'b0;
    m_ready = 1'b1;
    ticks(40);
    chk("final_fill", fill_count, 0);
    chk("final_credits", credits, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
